// File: rtl/sd_wr_pkg.sv
// rtl/sd_wr_pkg.sv - shared state encoding and sector constants for the frame write scheduler
package sd_wr_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SEC_WORDS    = SECTOR_BYTES / 2;

    // One-hot scheduler states
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_WAIT_DATA = 6'b000010,
        ST_REQ       = 6'b000100,
        ST_ACK       = 6'b001000,
        ST_BUSY      = 6'b010000,
        ST_NEXT      = 6'b100000
    } wr_state_t;

    // Width of a slot index; a single-slot ring still gets one bit
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_wr_addr_gen.sv
// rtl/sd_wr_addr_gen.sv - slot/sector counters and sector address for the frame write scheduler
module sd_wr_addr_gen #(
    parameter logic [31:0] BASE_ADDR     = 32'd0,
    parameter logic [15:0] SEC_PER_FRAME = 16'd2,
    parameter int          NUM_SLOTS     = 8,
    parameter int          SLOT_W        = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              clr_sec,
    input  logic              inc_sec,
    input  logic              inc_slot,
    output logic [SLOT_W-1:0] cur_slot,
    output logic              last_sec,
    output logic [31:0]       sec_addr
);

    logic [15:0] sec_cnt;
    logic        last_slot;

    assign last_slot = (cur_slot == SLOT_W'(NUM_SLOTS - 1));
    assign last_sec  = (sec_cnt == SEC_PER_FRAME - 16'd1);
    // Address arithmetic is deliberately 32-bit so it wraps mod 2^32
    assign sec_addr  = BASE_ADDR + (32'(cur_slot) * 32'(SEC_PER_FRAME)) + 32'(sec_cnt);

    // Sector counter restarts per frame; slot index wraps around the ring
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sec_cnt  <= 16'd0;
            cur_slot <= '0;
        end else begin
            if (clr_sec) begin
                sec_cnt <= 16'd0;
            end else if (inc_sec) begin
                sec_cnt <= sec_cnt + 16'd1;
            end
            if (inc_slot) begin
                cur_slot <= last_slot ? '0 : cur_slot + SLOT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sd_frame_wr_sched.sv
// rtl/sd_frame_wr_sched.sv - per-frame multi-sector SD write sequencer (optional watchdog: SD_WR_TIMEOUT_EN)
module sd_frame_wr_sched
    import sd_wr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'd0,
    parameter logic [15:0] SEC_PER_FRAME = 16'd2,
    parameter int          NUM_SLOTS     = 8,
    parameter int          SEC_WORDS     = sd_wr_pkg::SEC_WORDS,
    parameter int          CNT_W         = 10,
    parameter logic [23:0] TIMEOUT_CYC   = 24'd5_000_000,
    localparam int         SLOT_W        = slot_width(NUM_SLOTS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  fifo_rd_cnt,
    input  logic              wr_busy,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic              sched_busy,
    output logic              frame_done,
    output logic              frame_drop,
    output logic [SLOT_W-1:0] cur_slot,
    output logic              wr_err
);

    wr_state_t   state;
    wr_state_t   state_nxt;
    logic        busy_d;
    logic        busy_fall;
    logic        fifo_ok;
    logic        clr_sec;
    logic        inc_sec;
    logic        inc_slot;
    logic        last_sec;
    logic [31:0] sec_addr;
    logic        wd_hit;

    assign busy_fall = !wr_busy && busy_d;
    assign fifo_ok   = (32'(fifo_rd_cnt) >= 32'(SEC_WORDS));

    sd_wr_addr_gen #(
        .BASE_ADDR     (BASE_ADDR),
        .SEC_PER_FRAME (SEC_PER_FRAME),
        .NUM_SLOTS     (NUM_SLOTS),
        .SLOT_W        (SLOT_W)
    ) u_addr_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr_sec   (clr_sec),
        .inc_sec   (inc_sec),
        .inc_slot  (inc_slot),
        .cur_slot  (cur_slot),
        .last_sec  (last_sec),
        .sec_addr  (sec_addr)
    );

`ifdef SD_WR_TIMEOUT_EN
    logic [23:0] wd_cnt;
    logic        wr_err_q;

    assign wd_hit = ((state == ST_ACK) || (state == ST_BUSY)) && (wd_cnt == TIMEOUT_CYC - 24'd1);
    assign wr_err = wr_err_q;

    // Handshake watchdog: restarts as ACK is entered, error is sticky until reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wd_cnt   <= 24'd0;
            wr_err_q <= 1'b0;
        end else begin
            if (state == ST_REQ) begin
                wd_cnt <= 24'd0;
            end else if ((state == ST_ACK) || (state == ST_BUSY)) begin
                wd_cnt <= wd_cnt + 24'd1;
            end
            if (wd_hit) begin
                wr_err_q <= 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    // Watchdog absent: the limit parameter stays in the interface so both builds instantiate alike
    assign wr_err = (TIMEOUT_CYC == 24'd0) & 1'b0;
`endif

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and counter strobes
    always_comb begin
        state_nxt = state;
        clr_sec   = 1'b0;
        inc_sec   = 1'b0;
        inc_slot  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start && init_end) begin
                    clr_sec   = 1'b1;
                    state_nxt = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (fifo_ok) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (wr_busy) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (busy_fall) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_sec) begin
                    inc_slot  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    inc_sec   = 1'b1;
                    state_nxt = ST_WAIT_DATA;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // A watchdog expiry abandons the frame without touching the counters
        if (wd_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    // Registered outputs and the busy edge-detect flop
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_d     <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 32'd0;
            sched_busy <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            busy_d     <= wr_busy;
            wr_en      <= (state == ST_REQ);
            if (state == ST_REQ) begin
                wr_addr <= sec_addr;
            end
            sched_busy <= (state_nxt != ST_IDLE);
            frame_done <= (state == ST_NEXT) && last_sec && !wd_hit;
            frame_drop <= frame_start && !((state == ST_IDLE) && init_end);
        end
    end

endmodule

// File: tb/tb_sd_frame_wr_sched.sv
// tb/tb_sd_frame_wr_sched.sv - randomized self-checking bench for sd_frame_wr_sched
module tb_sd_frame_wr_sched;

    localparam logic [31:0] BASE = 32'd0;
    localparam int          SPF  = 2;
    localparam int          NS   = 8;
`ifdef SD_WR_TIMEOUT_EN
    localparam logic [23:0] TMO  = 24'd100;
`else
    localparam logic [23:0] TMO  = 24'd5_000_000;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_end;
    logic        frame_start;
    logic [9:0]  fifo_rd_cnt;
    logic        wr_busy;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic        sched_busy;
    logic        frame_done;
    logic        frame_drop;
    logic [2:0]  cur_slot;
    logic        wr_err;

    sd_frame_wr_sched #(
        .BASE_ADDR     (BASE),
        .SEC_PER_FRAME (16'(SPF)),
        .NUM_SLOTS     (NS),
        .SEC_WORDS     (256),
        .CNT_W         (10),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .init_end    (init_end),
        .frame_start (frame_start),
        .fifo_rd_cnt (fifo_rd_cnt),
        .wr_busy     (wr_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sched_busy  (sched_busy),
        .frame_done  (frame_done),
        .frame_drop  (frame_drop),
        .cur_slot    (cur_slot),
        .wr_err      (wr_err)
    );

    always #10 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_slot   = 0;
    int          exp_done = 0;
    int          exp_drop = 0;
    int          done_cnt = 0;
    int          drop_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          eng_on   = 1'b1;
    int          eng_hold = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: an accepted frame writes SPF consecutive sectors of its slot, then the ring advances
    task automatic model_accept();
        for (int s = 0; s < SPF; s++) begin
            exp_q.push_back(BASE + 32'(m_slot * SPF + s));
        end
        m_slot   = (m_slot + 1) % NS;
        exp_done = exp_done + 1;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic finish_frame();
        int n;
        for (int k = 0; k < 3000 && done_cnt < exp_done; k++) tick();
        repeat (3) tick();
        check_val("frame_done_count", done_cnt, exp_done);
        check_val("wr_count", got_q.size(), exp_q.size());
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q.size() > 0) begin
                check_val("wr_addr", got_q.pop_front(), exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
        got_q.delete();
        check_val("cur_slot", 32'(cur_slot), m_slot);
        check_val("frame_drop_count", drop_cnt, exp_drop);
        check_val("sched_busy_idle", sched_busy, 1'b0);
    endtask

    // Observe DUT events half a cycle away from the active edge
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (wr_en) got_q.push_back(wr_addr);
            if (frame_done) done_cnt++;
            if (frame_drop) drop_cnt++;
        end
    end

    // SD write engine: random response delay and busy length per request
    initial begin
        wr_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (wr_en && eng_on) begin
                repeat ($urandom_range(1, 3)) @(posedge sys_clk);
                #1 wr_busy = 1'b1;
                repeat ($urandom_range(1, 4) + eng_hold) @(posedge sys_clk);
                #1 wr_busy = 1'b0;
            end
        end
    end

    initial begin
        int lat;
        bit low;
        sys_rst_n   = 1'b0;
        init_end    = 1'b0;
        frame_start = 1'b0;
        fifo_rd_cnt = 10'd0;
        repeat (3) tick();
        check_val("rst_wr_en", wr_en, 1'b0);
        check_val("rst_wr_addr", wr_addr, 32'd0);
        check_val("rst_sched_busy", sched_busy, 1'b0);
        check_val("rst_frame_done", frame_done, 1'b0);
        check_val("rst_frame_drop", frame_drop, 1'b0);
        check_val("rst_cur_slot", 32'(cur_slot), 32'd0);
        check_val("rst_wr_err", wr_err, 1'b0);
        sys_rst_n = 1'b1;
        tick();

        // First frame with data already waiting: minimum latency
        init_end    = 1'b1;
        fifo_rd_cnt = 10'd300;
        frame_start = 1'b1;
        model_accept();
        @(posedge sys_clk);
        #1 frame_start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (wr_en) begin
                lat = i;
                break;
            end
        end
        check_val("start_to_wr_en", lat, 3);
        finish_frame();

        // FIFO one word short of a sector holds the request back
        fifo_rd_cnt = 10'd255;
        pulse_start();
        model_accept();
        repeat (100) tick();
        check_val("no_wr_below_level", got_q.size(), 0);
        check_val("busy_while_waiting", sched_busy, 1'b1);
        fifo_rd_cnt = 10'd256;
        @(posedge sys_clk);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (wr_en) begin
                lat = i;
                break;
            end
        end
        check_val("level_to_wr_en", lat, 2);
        finish_frame();

        // Start before card init is dropped and leaves the scheduler idle
        init_end = 1'b0;
        pulse_start();
        exp_drop++;
        tick();
        check_val("idle_without_init", sched_busy, 1'b0);
        check_val("drop_without_init", drop_cnt, exp_drop);
        init_end = 1'b1;

        // Randomized frames: FIFO level, early drops, mid-frame starts, init_end glitches
        for (int f = 0; f < 11; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                init_end = 1'b0;
                pulse_start();
                exp_drop++;
                tick();
            end
            init_end    = 1'b1;
            low         = 1'($urandom_range(0, 1));
            fifo_rd_cnt = low ? 10'($urandom_range(0, 255)) : 10'($urandom_range(256, 1023));
            pulse_start();
            model_accept();
            if (low) begin
                repeat ($urandom_range(1, 20)) tick();
                fifo_rd_cnt = 10'($urandom_range(256, 1023));
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 500 && got_q.size() == 0; k++) tick();
                if ($urandom_range(0, 1) == 1) init_end = 1'b0;
                pulse_start();
                exp_drop++;
            end
            finish_frame();
            init_end = 1'b1;
        end

        // Reset in the middle of a sector write
        eng_hold    = 30;
        fifo_rd_cnt = 10'd300;
        pulse_start();
        for (int k = 0; k < 200 && !wr_busy; k++) tick();
        repeat (3) tick();
        check_val("busy_before_reset", sched_busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check_val("arst_wr_en", wr_en, 1'b0);
        check_val("arst_wr_addr", wr_addr, 32'd0);
        check_val("arst_sched_busy", sched_busy, 1'b0);
        check_val("arst_cur_slot", 32'(cur_slot), 32'd0);
        check_val("arst_frame_done", frame_done, 1'b0);
        check_val("arst_frame_drop", frame_drop, 1'b0);
        for (int k = 0; k < 200 && wr_busy; k++) tick();
        tick();
        sys_rst_n = 1'b1;
        eng_hold  = 0;
        exp_q.delete();
        got_q.delete();
        m_slot = 0;
        tick();
        check_val("no_done_on_reset", done_cnt, exp_done);
        pulse_start();
        model_accept();
        finish_frame();

`ifdef SD_WR_TIMEOUT_EN
        // Engine never answers: watchdog gives up without completing the frame
        eng_on = 1'b0;
        pulse_start();
        repeat (130) tick();
        check_val("timeout_wr_err", wr_err, 1'b1);
        check_val("timeout_idle", sched_busy, 1'b0);
        check_val("timeout_cur_slot", 32'(cur_slot), m_slot);
        check_val("timeout_no_done", done_cnt, exp_done);
        got_q.delete();
`else
        check_val("wr_err_tied", wr_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
